lab_buffer_manager: RTL and testbench
=====================================

Name: lab_buffer_manager

Overview:
Tracks the four LAB analog buffers between the command receiver and the local-bus readout interface. Accepts per-buffer digitize requests from the command receiver and serialises them to the LAB digitizer one at a time, in arrival order. Marks each buffer READY when digitization completes, and drives the lab_ready flag that the bus interface reports for the event at the head of the event FIFO. Frees a buffer when software clears that event.

Parameters:
NUM_BUF, 4, number of LAB buffers; fixed at 4 (2-bit index).
DIG_TIMEOUT, 16'd50000, clk_i cycles to wait for dig_done_i; used only with the optional feature.

Ports:
clk_i  in  1  system clock (33 MHz local-bus clock)
rst_i  in  1  synchronous active-high reset
digitize_i  in  4  one-hot digitize request pulses from the command receiver, one bit per buffer
dig_start_o  out  1  one-cycle pulse that starts digitization of dig_buffer_o
dig_buffer_o  out  2  buffer index for the digitizer; held stable from dig_start_o until dig_done_i
dig_done_i  in  1  one-cycle pulse from the digitizer when the current buffer is complete
read_valid_i  in  1  event FIFO not empty
read_buffer_i  in  2  buffer index at the head of the event FIFO
clr_evt_i  in  1  one-cycle release of buffer read_buffer_i (software event clear)
lab_ready_o  out  1  head event's buffer is READY
buf_ready_o  out  4  per-buffer READY bits
buf_busy_o  out  4  per-buffer bits, set for PENDING or DIGITIZING
err_o  out  1  sticky protocol error; cleared only by rst_i

Behaviour:
- Per-buffer state: FREE(0), PENDING(1), DIGITIZING(2), READY(3).
- Reset: all buffers FREE, queue empty, scheduler IDLE, all outputs 0.
- Request acceptance:
  - If digitize_i bit b is set and buffer b is FREE: buffer b becomes PENDING and index b is pushed into a 4-deep index queue (cycle N to N+1).
  - If buffer b is not FREE: the request is dropped and err_o is set.
  - If more than one digitize_i bit is set in a cycle: the lowest index is accepted, the rest are dropped, and err_o is set.
- Queue:
  - It can never overflow, because each buffer occupies at most one entry.
  - A push and a pop in the same cycle are both honoured.
- Scheduler FSM:
  - IDLE: when the queue is non-empty, pop the head into dig_buffer_o and go to START.
  - START: pulse dig_start_o for 1 cycle, set the buffer to DIGITIZING, go to WAIT.
  - WAIT: on dig_done_i, set the buffer to READY and go to IDLE.
  - Latency from an idle system: digitize_i at N, PENDING at N+1, dig_start_o asserted at N+3.
  - dig_done_i outside WAIT is ignored and sets err_o.
- READY to FREE:
  - If clr_evt_i and buffer read_buffer_i is READY, it becomes FREE on the next cycle.
  - If clr_evt_i targets a buffer that is not READY, the clear is ignored and err_o is set.
  - A clear and a digitize request for the same buffer in the same cycle: release first, then the request is accepted, so the buffer ends PENDING.
- lab_ready_o: registered; equals read_valid_i AND (state[read_buffer_i]==READY), one cycle after its inputs.
- buf_ready_o and buf_busy_o: registered decodes of the state vector.
- Reset mid-digitization: everything returns to reset values; a later dig_done_i is ignored without setting err_o.

Optional Feature:
LAB_DIG_TIMEOUT_EN
- Defined:
  - A 16-bit counter runs in WAIT.
  - If it reaches DIG_TIMEOUT-1 without dig_done_i, the buffer is forced READY, err_o is set, and the FSM returns to IDLE. This keeps readout from deadlocking.
  - If dig_done_i arrives in the same cycle as the timeout, done wins and err_o is not set.
- Undefined: no counter; WAIT holds until dig_done_i or rst_i.

Decomposition:
- Package lab_buf_pkg:
  - NUM_BUF.
  - Buffer state encodings FREE/PENDING/DIGITIZING/READY.
  - Scheduler state encodings IDLE/START/WAIT.
  - Default DIG_TIMEOUT.
- Sub-module lab_buf_idx_fifo: 4-entry x 2-bit synchronous queue with push, pop, empty and head outputs, same clk_i/rst_i.

Test Plan:
- Reset, then digitize_i=4'b0100 at cycle N → dig_start_o at N+3 with dig_buffer_o=2; dig_done_i 10 cycles later → buf_ready_o=4'b0100; with read_valid_i=1, read_buffer_i=2, lab_ready_o=1 one cycle later.
- digitize_i 4'b0001, 4'b1000, 4'b0010 on consecutive cycles → starts for 0, 3, 1 in order; each start follows the previous dig_done_i; err_o stays 0.
- Buffer 1 READY; clr_evt_i with read_buffer_i=1 and digitize_i=4'b0010 in the same cycle → buffer 1 PENDING, buf_busy_o[1]=1, err_o=0.
- digitize_i=4'b0101 → buffer 0 accepted, buffer 2 stays FREE, err_o=1; a repeat request for buffer 0 while it is PENDING → no second start.
- rst_i asserted in WAIT for buffer 3 → all outputs 0; a stray dig_done_i 2 cycles later → no state change, err_o=0.
- With LAB_DIG_TIMEOUT_EN and DIG_TIMEOUT=20: no dig_done_i → buffer READY and err_o=1 exactly 20 cycles after entering WAIT; without the macro → still DIGITIZING after 1000 cycles.

Source files
------------

// File: rtl/lab_buf_pkg.sv
// lab_buf_pkg: shared definitions for the LAB buffer manager.
//   NUM_BUF              number of LAB analog buffers (2-bit index)
//   DIG_TIMEOUT_DEFAULT  default digitizer watchdog length in clk_i cycles
//   buf_state_t          per-buffer lifecycle state
//   sch_state_t          digitizer scheduler state
//   lowest_set()         index of the lowest set bit of a 4-bit request vector
package lab_buf_pkg;

    localparam int NUM_BUF = 4;
    localparam logic [15:0] DIG_TIMEOUT_DEFAULT = 16'd50000;

    typedef enum logic [1:0] {
        BUF_FREE       = 2'd0,
        BUF_PENDING    = 2'd1,
        BUF_DIGITIZING = 2'd2,
        BUF_READY      = 2'd3
    } buf_state_t;

    typedef enum logic [1:0] {
        SCH_IDLE  = 2'd0,
        SCH_START = 2'd1,
        SCH_WAIT  = 2'd2
    } sch_state_t;

    function automatic logic [1:0] lowest_set(input logic [NUM_BUF-1:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        casez (v)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/lab_buf_idx_fifo.sv
// lab_buf_idx_fifo: 4-entry x 2-bit queue of buffer indices awaiting digitization.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   push, push_idx    enqueue push_idx
//   pop               dequeue the head (ignored when empty)
//   empty, head       queue status and current head index
// A simultaneous push and pop are both honoured. Each buffer holds at most
// one entry, so the queue cannot overflow; a push while full is still guarded.
module lab_buf_idx_fifo
    import lab_buf_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push,
    input  logic [1:0] push_idx,
    input  logic       pop,
    output logic       empty,
    output logic [1:0] head
);

    logic [1:0] mem [NUM_BUF];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;
    logic       do_push;
    logic       do_pop;

    assign empty   = (count == 3'd0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && ((count != 3'd4) || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_BUF; i++) begin
                mem[i] <= 2'd0;
            end
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_idx;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lab_buffer_manager.sv
// lab_buffer_manager: tracks the four LAB analog buffers from digitize request
// through readout, serialising digitizations in arrival order.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// SCH_IDLE   | digitizer free; pop the next queued buffer if any
// SCH_START  | issue dig_start_o for dig_buffer_o, buffer -> DIGITIZING
// SCH_WAIT   | wait for dig_done_i (or watchdog), buffer -> READY
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   digitize_i[3:0]           one-hot digitize request pulses
//   dig_start_o, dig_buffer_o start pulse and buffer index to the digitizer
//   dig_done_i                digitizer completion pulse
//   read_valid_i, read_buffer_i  event FIFO head status and buffer index
//   clr_evt_i                 release read_buffer_i back to FREE
//   lab_ready_o               head event's buffer is READY (registered)
//   buf_ready_o, buf_busy_o   per-buffer READY / (PENDING|DIGITIZING) bits
//   err_o                     sticky protocol error
//
// Build option: define LAB_DIG_TIMEOUT_EN to add a watchdog of DIG_TIMEOUT
// cycles in SCH_WAIT that forces the buffer READY and flags err_o.
module lab_buffer_manager
    import lab_buf_pkg::*;
`ifdef LAB_DIG_TIMEOUT_EN
#(
    parameter logic [15:0] DIG_TIMEOUT = DIG_TIMEOUT_DEFAULT
)
`endif
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_BUF-1:0] digitize_i,
    output logic               dig_start_o,
    output logic [1:0]         dig_buffer_o,
    input  logic               dig_done_i,
    input  logic               read_valid_i,
    input  logic [1:0]         read_buffer_i,
    input  logic               clr_evt_i,
    output logic               lab_ready_o,
    output logic [NUM_BUF-1:0] buf_ready_o,
    output logic [NUM_BUF-1:0] buf_busy_o,
    output logic               err_o
);

    buf_state_t state_q [NUM_BUF];
    buf_state_t state_d [NUM_BUF];
    sch_state_t sch_q;
    sch_state_t sch_d;

    logic [1:0]         dig_buf_q;
    logic               dig_start_q;
    logic               start_d;
    logic               err_q;
    logic               err_set;
    logic               lab_ready_q;
    logic [NUM_BUF-1:0] buf_ready_q;
    logic [NUM_BUF-1:0] buf_busy_q;
    // Set by reset, cleared by the first start: a done pulse from a conversion
    // aborted by reset must not be reported as a protocol error.
    logic               stray_ok_q;

    logic       fifo_push;
    logic [1:0] fifo_push_idx;
    logic       fifo_pop;
    logic       fifo_empty;
    logic [1:0] fifo_head;

`ifdef LAB_DIG_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;
    logic        tmo_hit;
    assign tmo_hit = (tmo_cnt_q == 16'd0);
`endif

    lab_buf_idx_fifo u_idx_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push     (fifo_push),
        .push_idx (fifo_push_idx),
        .pop      (fifo_pop),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

    always_comb begin
        for (int i = 0; i < NUM_BUF; i++) begin
            state_d[i] = state_q[i];
        end
        sch_d         = sch_q;
        fifo_pop      = 1'b0;
        fifo_push     = 1'b0;
        fifo_push_idx = lowest_set(digitize_i);
        start_d       = 1'b0;
        err_set       = 1'b0;

        case (sch_q)
            SCH_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    sch_d    = SCH_START;
                end
            end
            SCH_START: begin
                start_d            = 1'b1;
                state_d[dig_buf_q] = BUF_DIGITIZING;
                sch_d              = SCH_WAIT;
            end
            SCH_WAIT: begin
                if (dig_done_i) begin
                    state_d[dig_buf_q] = BUF_READY;
                    sch_d              = SCH_IDLE;
                end
`ifdef LAB_DIG_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d[dig_buf_q] = BUF_READY;
                    err_set            = 1'b1;
                    sch_d              = SCH_IDLE;
                end
`endif
            end
            default: sch_d = SCH_IDLE;
        endcase

        if (dig_done_i && (sch_q != SCH_WAIT) && !stray_ok_q) begin
            err_set = 1'b1;
        end

        // Release is evaluated before the request so a same-cycle clear and
        // re-request of one buffer leaves it PENDING.
        if (clr_evt_i) begin
            if (state_q[read_buffer_i] == BUF_READY) begin
                state_d[read_buffer_i] = BUF_FREE;
            end else begin
                err_set = 1'b1;
            end
        end

        if (digitize_i != '0) begin
            if ((digitize_i & (digitize_i - 4'd1)) != '0) begin
                err_set = 1'b1;
            end
            if (state_d[fifo_push_idx] == BUF_FREE) begin
                state_d[fifo_push_idx] = BUF_PENDING;
                fifo_push              = 1'b1;
            end else begin
                err_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_BUF; i++) begin
                state_q[i] <= BUF_FREE;
            end
            sch_q       <= SCH_IDLE;
            dig_buf_q   <= 2'd0;
            dig_start_q <= 1'b0;
            err_q       <= 1'b0;
            lab_ready_q <= 1'b0;
            buf_ready_q <= '0;
            buf_busy_q  <= '0;
            stray_ok_q  <= 1'b1;
        end else begin
            for (int i = 0; i < NUM_BUF; i++) begin
                state_q[i]     <= state_d[i];
                buf_ready_q[i] <= (state_d[i] == BUF_READY);
                buf_busy_q[i]  <= (state_d[i] == BUF_PENDING) ||
                                  (state_d[i] == BUF_DIGITIZING);
            end
            sch_q       <= sch_d;
            dig_start_q <= start_d;
            err_q       <= err_q | err_set;
            lab_ready_q <= read_valid_i && (state_q[read_buffer_i] == BUF_READY);
            if (fifo_pop) begin
                dig_buf_q <= fifo_head;
            end
            if (start_d) begin
                stray_ok_q <= 1'b0;
            end
        end
    end

`ifdef LAB_DIG_TIMEOUT_EN
    // Down-counter loaded on entry to SCH_WAIT; terminal count 0 lands
    // exactly DIG_TIMEOUT cycles after SCH_WAIT is entered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_cnt_q <= 16'd0;
        end else if (sch_q == SCH_START) begin
            tmo_cnt_q <= DIG_TIMEOUT - 16'd1;
        end else if ((sch_q == SCH_WAIT) && !tmo_hit) begin
            tmo_cnt_q <= tmo_cnt_q - 16'd1;
        end
    end
`endif

    assign dig_start_o  = dig_start_q;
    assign dig_buffer_o = dig_buf_q;
    assign err_o        = err_q;
    assign lab_ready_o  = lab_ready_q;
    assign buf_ready_o  = buf_ready_q;
    assign buf_busy_o   = buf_busy_q;

endmodule

// File: tb/tb_lab_buffer_manager.sv
module tb_lab_buffer_manager;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [3:0] digitize_i;
    logic       dig_start_o;
    logic [1:0] dig_buffer_o;
    logic       dig_done_i;
    logic       read_valid_i;
    logic [1:0] read_buffer_i;
    logic       clr_evt_i;
    logic       lab_ready_o;
    logic [3:0] buf_ready_o;
    logic [3:0] buf_busy_o;
    logic       err_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [1:0] exp_q [$];

    always #15 clk_i = ~clk_i;

`ifdef LAB_DIG_TIMEOUT_EN
    lab_buffer_manager #(.DIG_TIMEOUT(16'd20)) dut (
`else
    lab_buffer_manager dut (
`endif
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .digitize_i    (digitize_i),
        .dig_start_o   (dig_start_o),
        .dig_buffer_o  (dig_buffer_o),
        .dig_done_i    (dig_done_i),
        .read_valid_i  (read_valid_i),
        .read_buffer_i (read_buffer_i),
        .clr_evt_i     (clr_evt_i),
        .lab_ready_o   (lab_ready_o),
        .buf_ready_o   (buf_ready_o),
        .buf_busy_o    (buf_busy_o),
        .err_o         (err_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every start pulse must match the oldest expected buffer index.
    always @(negedge clk_i) begin
        if (!rst_i && dig_start_o) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_start: got buffer %0d expected no start at %0t",
                         dig_buffer_o, $time);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                if (dig_buffer_o !== e) begin
                    n_bad++;
                    $display("FAIL start_order: got buffer %0d expected %0d at %0t",
                             dig_buffer_o, e, $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic wait_start();
        for (int i = 0; i < 100; i++) begin
            if (dig_start_o) return;
            tick();
        end
        n_cmp++;
        n_bad++;
        $display("FAIL wait_start: got no dig_start_o expected one within 100 cycles");
    endtask

    task automatic pulse_done();
        dig_done_i = 1'b1;
        tick();
        dig_done_i = 1'b0;
    endtask

    typedef struct {
        logic [3:0] dig;
        logic       clr;
        logic [1:0] rb;
        logic [3:0] exp_busy;
        logic       exp_err;
        logic [1:0] exp_idx;
    } vec_t;

    vec_t vecs [8];

    initial begin
        rst_i = 1'b1; digitize_i = 4'd0; dig_done_i = 1'b0;
        read_valid_i = 1'b0; read_buffer_i = 2'd0; clr_evt_i = 1'b0;

        vecs[0] = '{4'b0001, 1'b0, 2'd0, 4'b0001, 1'b0, 2'd0};
        vecs[1] = '{4'b0100, 1'b0, 2'd0, 4'b0100, 1'b0, 2'd2};
        vecs[2] = '{4'b1000, 1'b0, 2'd0, 4'b1000, 1'b0, 2'd3};
        vecs[3] = '{4'b0101, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0};
        vecs[4] = '{4'b1100, 1'b0, 2'd0, 4'b0100, 1'b1, 2'd2};
        vecs[5] = '{4'b1111, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0};
        vecs[6] = '{4'b0000, 1'b1, 2'd3, 4'b0000, 1'b1, 2'd0};
        vecs[7] = '{4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0};

        do_reset();
        check("reset_start", {31'd0, dig_start_o}, 0);
        check("reset_bufidx", {30'd0, dig_buffer_o}, 0);
        check("reset_ready", {28'd0, buf_ready_o}, 0);
        check("reset_busy", {28'd0, buf_busy_o}, 0);
        check("reset_labrdy", {31'd0, lab_ready_o}, 0);
        check("reset_err", {31'd0, err_o}, 0);

        // Single-cycle request acceptance from reset, then 3-cycle start latency.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            digitize_i = vecs[v].dig;
            clr_evt_i = vecs[v].clr;
            read_buffer_i = vecs[v].rb;
            if (vecs[v].exp_busy != 4'd0) exp_q.push_back(vecs[v].exp_idx);
            tick();
            digitize_i = 4'd0; clr_evt_i = 1'b0;
            check($sformatf("vec%0d_busy", v), {28'd0, buf_busy_o}, {28'd0, vecs[v].exp_busy});
            check($sformatf("vec%0d_err", v), {31'd0, err_o}, {31'd0, vecs[v].exp_err});
            tick();
            tick();
            check($sformatf("vec%0d_start_lat", v), {31'd0, dig_start_o},
                  {31'd0, (vecs[v].exp_busy != 4'd0)});
            tick();
        end

        // Digitize buffer 2, complete, then report lab_ready for it.
        do_reset();
        digitize_i = 4'b0100; exp_q.push_back(2'd2);
        tick();
        digitize_i = 4'd0;
        tick();
        tick();
        check("seq1_start", {31'd0, dig_start_o}, 1);
        repeat (10) tick();
        check("seq1_still_busy", {28'd0, buf_busy_o}, 32'h4);
        pulse_done();
        check("seq1_ready", {28'd0, buf_ready_o}, 32'h4);
        read_valid_i = 1'b1; read_buffer_i = 2'd2;
        check("seq1_labrdy_lag", {31'd0, lab_ready_o}, 0);
        tick();
        check("seq1_labrdy", {31'd0, lab_ready_o}, 1);
        read_buffer_i = 2'd0;
        tick();
        check("seq1_labrdy_other", {31'd0, lab_ready_o}, 0);
        read_valid_i = 1'b0;

        // Three back-to-back requests served in arrival order.
        do_reset();
        digitize_i = 4'b0001; exp_q.push_back(2'd0); tick();
        digitize_i = 4'b1000; exp_q.push_back(2'd3); tick();
        digitize_i = 4'b0010; exp_q.push_back(2'd1); tick();
        digitize_i = 4'd0;
        for (int k = 0; k < 3; k++) begin
            wait_start();
            repeat (4) tick();
            pulse_done();
        end
        check("seq2_ready", {28'd0, buf_ready_o}, 32'hB);
        check("seq2_err", {31'd0, err_o}, 0);

        // Clear and re-request buffer 1 in the same cycle.
        clr_evt_i = 1'b1; read_buffer_i = 2'd1; digitize_i = 4'b0010;
        exp_q.push_back(2'd1);
        tick();
        clr_evt_i = 1'b0; digitize_i = 4'd0;
        check("seq3_busy", {28'd0, buf_busy_o}, 32'h2);
        check("seq3_ready", {28'd0, buf_ready_o}, 32'h9);
        check("seq3_err", {31'd0, err_o}, 0);
        wait_start();
        tick();
        pulse_done();
        check("seq3_ready2", {28'd0, buf_ready_o}, 32'hB);
        tick();
        pulse_done();
        check("seq3_stray_done_err", {31'd0, err_o}, 1);

        // Multi-bit request and duplicate request while PENDING.
        do_reset();
        digitize_i = 4'b0101; exp_q.push_back(2'd0); tick();
        digitize_i = 4'b0001; tick();
        digitize_i = 4'd0;
        check("seq4_busy", {28'd0, buf_busy_o}, 32'h1);
        check("seq4_err", {31'd0, err_o}, 1);
        wait_start();
        repeat (12) tick();
        pulse_done();
        check("seq4_ready", {28'd0, buf_ready_o}, 32'h1);
        repeat (6) tick();

        // Reset while waiting on buffer 3, then a stray done.
        do_reset();
        digitize_i = 4'b1000; exp_q.push_back(2'd3); tick();
        digitize_i = 4'd0;
        wait_start();
        repeat (3) tick();
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        check("seq5_start", {31'd0, dig_start_o}, 0);
        check("seq5_bufidx", {30'd0, dig_buffer_o}, 0);
        check("seq5_busy", {28'd0, buf_busy_o}, 0);
        check("seq5_ready", {28'd0, buf_ready_o}, 0);
        check("seq5_err", {31'd0, err_o}, 0);
        tick();
        pulse_done();
        check("seq5_stray_err", {31'd0, err_o}, 0);
        check("seq5_stray_ready", {28'd0, buf_ready_o}, 0);
        check("seq5_stray_busy", {28'd0, buf_busy_o}, 0);

        // Digitizer never answers.
        do_reset();
        digitize_i = 4'b0001; exp_q.push_back(2'd0); tick();
        digitize_i = 4'd0;
        wait_start();
`ifdef LAB_DIG_TIMEOUT_EN
        repeat (19) tick();
        check("tmo_ready_early", {28'd0, buf_ready_o}, 0);
        check("tmo_err_early", {31'd0, err_o}, 0);
        tick();
        check("tmo_ready", {28'd0, buf_ready_o}, 32'h1);
        check("tmo_err", {31'd0, err_o}, 1);
`else
        repeat (1000) tick();
        check("notmo_busy", {28'd0, buf_busy_o}, 32'h1);
        check("notmo_ready", {28'd0, buf_ready_o}, 0);
        check("notmo_err", {31'd0, err_o}, 0);
        pulse_done();
        check("notmo_done_ready", {28'd0, buf_ready_o}, 32'h1);
`endif
        repeat (4) tick();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
